// File: rtl/map_server.sv
// Game-field wall bitmap: fixed-latency VGA read port, stallable game read/write port,
// and an init sweep that clears the field and draws the border walls.
module map_server #(
   parameter int unsigned MAP_W = 64,
   parameter int unsigned MAP_H = 44,
   parameter int unsigned CW    = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_init,
   output logic          o_init_done,
   input  logic          i_vga_buzy,
   input  logic [CW-1:0] i_vga_x,
   input  logic [CW-1:0] i_vga_y,
   output logic          o_vga_is_wall,
   input  logic          i_req_valid,
   input  logic          i_req_write,
   input  logic [CW-1:0] i_req_x,
   input  logic [CW-1:0] i_req_y,
   input  logic          i_req_wdata,
   output logic          o_req_ready,
   output logic          o_req_rvalid,
   output logic          o_req_rdata
);

   localparam int unsigned DEPTH = MAP_W * MAP_H;
   localparam int unsigned AW    = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, INIT, READY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] ptr_x_q, ptr_y_q, ptr_x_d, ptr_y_d;
   logic          init_done_d;

   logic          mem [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic          mem_wdata;

   logic          accept_c;
   logic          req_in_map_c;
   logic          vga_in_map_c;
   logic          vga_bit_c;
   logic          req_bit_c;
   logic          ptr_border_c;
   logic          ptr_last_c;

   function automatic logic [AW-1:0] cell_addr(input logic [CW-1:0] x, input logic [CW-1:0] y);
      return AW'(AW'(y) * AW'(MAP_W) + AW'(x));
   endfunction

   assign o_req_ready  = (state_q == READY) && !i_vga_buzy;
   assign accept_c     = i_req_valid && o_req_ready;
   assign req_in_map_c = i_req_y < CW'(MAP_H);
   assign vga_in_map_c = i_vga_y < CW'(MAP_H);

   // Rows past the field read as wall so the renderer never walks off the map.
   assign vga_bit_c = vga_in_map_c ? mem[cell_addr(i_vga_x, vga_in_map_c ? i_vga_y : '0)] : 1'b1;
   assign req_bit_c = req_in_map_c ? mem[cell_addr(i_req_x, req_in_map_c ? i_req_y : '0)] : 1'b1;

   assign ptr_border_c = (ptr_x_q == '0) || (ptr_x_q == CW'(MAP_W - 1)) ||
                         (ptr_y_q == '0) || (ptr_y_q == CW'(MAP_H - 1));
   assign ptr_last_c   = (ptr_x_q == CW'(MAP_W - 1)) && (ptr_y_q == CW'(MAP_H - 1));

   // State register, sweep pointer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_x_q       <= '0;
         ptr_y_q       <= '0;
         o_init_done   <= 1'b0;
         o_vga_is_wall <= 1'b0;
         o_req_rvalid  <= 1'b0;
         o_req_rdata   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_x_q       <= ptr_x_d;
         ptr_y_q       <= ptr_y_d;
         o_init_done   <= init_done_d;
         o_vga_is_wall <= (state_q == READY) ? vga_bit_c : 1'b0;
         o_req_rvalid  <= accept_c && !i_req_write;
         o_req_rdata   <= (accept_c && !i_req_write) ? req_bit_c : 1'b0;
      end
   end

   // Next state, sweep pointer and the single bitmap write port.
   always_comb begin
      state_d   = state_q;
      ptr_x_d   = ptr_x_q;
      ptr_y_d   = ptr_y_q;
      mem_we    = 1'b0;
      mem_waddr = cell_addr(i_req_x, req_in_map_c ? i_req_y : '0);
      mem_wdata = i_req_wdata;
      case (state_q)
         IDLE: begin
            if (i_init) begin
               state_d = INIT;
               ptr_x_d = '0;
               ptr_y_d = '0;
            end
         end
         INIT: begin
            if (i_init) begin
               ptr_x_d = '0;
               ptr_y_d = '0;
            end else begin
               mem_we    = 1'b1;
               mem_waddr = cell_addr(ptr_x_q, ptr_y_q);
               mem_wdata = ptr_border_c;
               if (ptr_last_c) begin
                  state_d = READY;
                  ptr_x_d = '0;
                  ptr_y_d = '0;
               end else if (ptr_x_q == CW'(MAP_W - 1)) begin
                  ptr_x_d = '0;
                  ptr_y_d = ptr_y_q + CW'(1);
               end else begin
                  ptr_x_d = ptr_x_q + CW'(1);
               end
            end
         end
         READY: begin
            mem_we = accept_c && i_req_write && req_in_map_c;
            if (i_init) begin
               state_d = INIT;
               ptr_x_d = '0;
               ptr_y_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      init_done_d = (state_d == READY);
   end

   // Bitmap storage is deliberately left unreset; INIT defines its contents.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

endmodule

// File: tb/tb_map_server.sv
// Self-checking bench for map_server: init sweep, border map, game port, buzy stall, re-init.
module tb_map_server;
   localparam int MAP_W = 64;
   localparam int MAP_H = 44;
   localparam int CW    = 6;
   localparam int CELLS = MAP_W * MAP_H;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_init = 1'b0;
   logic          o_init_done;
   logic          i_vga_buzy = 1'b0;
   logic [CW-1:0] i_vga_x = '0;
   logic [CW-1:0] i_vga_y = '0;
   logic          o_vga_is_wall;
   logic          i_req_valid = 1'b0;
   logic          i_req_write = 1'b0;
   logic [CW-1:0] i_req_x = '0;
   logic [CW-1:0] i_req_y = '0;
   logic          i_req_wdata = 1'b0;
   logic          o_req_ready;
   logic          o_req_rvalid;
   logic          o_req_rdata;

   int checks = 0;
   int errors = 0;
   bit ref_map [CELLS];
   bit q_vga [$];
   bit q_rd [$];

   map_server dut (
      .clk(clk), .rst_n(rst_n), .i_init(i_init), .o_init_done(o_init_done),
      .i_vga_buzy(i_vga_buzy), .i_vga_x(i_vga_x), .i_vga_y(i_vga_y),
      .o_vga_is_wall(o_vga_is_wall), .i_req_valid(i_req_valid), .i_req_write(i_req_write),
      .i_req_x(i_req_x), .i_req_y(i_req_y), .i_req_wdata(i_req_wdata),
      .o_req_ready(o_req_ready), .o_req_rvalid(o_req_rvalid), .o_req_rdata(o_req_rdata)
   );

   always #5 clk = ~clk;

   function automatic bit border(int x, int y);
      return (x == 0) || (x == MAP_W - 1) || (y == 0) || (y == MAP_H - 1);
   endfunction

   function automatic bit ref_cell(int x, int y);
      if (y >= MAP_H) return 1'b1;
      return ref_map[y * MAP_W + x];
   endfunction

   task automatic load_border_model();
      for (int y = 0; y < MAP_H; y++)
         for (int x = 0; x < MAP_W; x++) ref_map[y * MAP_W + x] = border(x, y);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit want;
      rst_n = 1'b0;
      i_init = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (o_init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", o_init_done); end
      checks++; if (o_vga_is_wall !== 1'b0) begin errors++; $display("FAIL reset_vga_is_wall got %b want 0", o_vga_is_wall); end
      checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", o_req_ready); end
      checks++; if (o_req_rvalid !== 1'b0) begin errors++; $display("FAIL reset_req_rvalid got %b want 0", o_req_rvalid); end
      checks++; if (o_req_rdata !== 1'b0) begin errors++; $display("FAIL reset_req_rdata got %b want 0", o_req_rdata); end
      @(negedge clk);
      i_init = 1'b0;
      rst_n = 1'b1;
      step();
      want = 1'b0;
      checks++; if (o_init_done !== want) begin errors++; $display("FAIL idle_init_done got %b want %b", o_init_done, want); end
   endtask

   // i_init sampled at edge 0; cells written on edges 1..CELLS; done only after the last one.
   task automatic test_init();
      bit want;
      @(negedge clk);
      i_init = 1'b1;
      i_vga_x = '0;
      i_vga_y = '0;
      step();
      @(negedge clk);
      i_init = 1'b0;
      for (int k = 1; k <= CELLS; k++) begin
         q_vga.push_back(1'b0);
         step();
         want = q_vga.pop_front();
         checks++; if (o_vga_is_wall !== want) begin errors++; $display("FAIL init_vga edge %0d got %b want %b", k, o_vga_is_wall, want); end
         want = (k == CELLS);
         checks++; if (o_init_done !== want) begin errors++; $display("FAIL init_done edge %0d got %b want %b", k, o_init_done, want); end
         if (k == 1) begin
            checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL init_req_ready got %b want 0", o_req_ready); end
         end
      end
      load_border_model();
   endtask

   task automatic test_border_sweep();
      bit want;
      for (int y = 0; y <= MAP_H; y++) begin
         for (int x = 0; x < MAP_W; x++) begin
            @(negedge clk);
            i_vga_x = CW'(x);
            i_vga_y = CW'(y);
            q_vga.push_back(ref_cell(x, y));
            step();
            want = q_vga.pop_front();
            checks++; if (o_vga_is_wall !== want) begin errors++; $display("FAIL sweep (%0d,%0d) got %b want %b", x, y, o_vga_is_wall, want); end
         end
      end
   endtask

   task automatic test_write_read();
      bit want;
      int rx [3] = '{10, 11, 0};
      int ry [3] = '{10, 10, 44};
      @(negedge clk);
      i_vga_buzy = 1'b0;
      i_req_valid = 1'b1; i_req_write = 1'b1; i_req_x = 6'd10; i_req_y = 6'd10; i_req_wdata = 1'b1;
      #1;
      checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b want 1", o_req_ready); end
      step();
      ref_map[10 * MAP_W + 10] = 1'b1;
      checks++; if (o_req_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b want 0", o_req_rvalid); end
      @(negedge clk);
      i_req_valid = 1'b0;
      i_vga_x = 6'd10; i_vga_y = 6'd10;
      q_vga.push_back(ref_cell(10, 10));
      step();
      want = q_vga.pop_front();
      checks++; if (o_vga_is_wall !== want) begin errors++; $display("FAIL wr_vga_see got %b want %b", o_vga_is_wall, want); end
      // Back-to-back reads, the last one below the field.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         i_req_valid = 1'b1; i_req_write = 1'b0; i_req_x = CW'(rx[i]); i_req_y = CW'(ry[i]);
         q_rd.push_back(ref_cell(rx[i], ry[i]));
         step();
         want = q_rd.pop_front();
         checks++; if (o_req_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid %0d got %b want 1", i, o_req_rvalid); end
         checks++; if (o_req_rdata !== want) begin errors++; $display("FAIL rd_data (%0d,%0d) got %b want %b", rx[i], ry[i], o_req_rdata, want); end
      end
      @(negedge clk);
      i_req_valid = 1'b0;
      step();
      checks++; if (o_req_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_drop got %b want 0", o_req_rvalid); end
   endtask

   task automatic test_buzy_stall();
      bit want;
      @(negedge clk);
      i_vga_buzy = 1'b1;
      i_req_valid = 1'b1; i_req_write = 1'b1; i_req_x = 6'd20; i_req_y = 6'd20; i_req_wdata = 1'b1;
      i_vga_x = 6'd20; i_vga_y = 6'd20;
      for (int i = 0; i < 20; i++) begin
         q_vga.push_back(ref_cell(20, 20));
         step();
         want = q_vga.pop_front();
         checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL buzy_ready cyc %0d got %b want 0", i, o_req_ready); end
         checks++; if (o_vga_is_wall !== want) begin errors++; $display("FAIL buzy_no_write cyc %0d got %b want %b", i, o_vga_is_wall, want); end
      end
      @(negedge clk);
      i_vga_buzy = 1'b0;
      #1;
      checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL unbuzy_ready got %b want 1", o_req_ready); end
      q_vga.push_back(ref_cell(20, 20));
      step();
      ref_map[20 * MAP_W + 20] = 1'b1;
      want = q_vga.pop_front();
      checks++; if (o_vga_is_wall !== want) begin errors++; $display("FAIL unbuzy_accept_edge got %b want %b", o_vga_is_wall, want); end
      @(negedge clk);
      i_req_valid = 1'b0;
      q_vga.push_back(ref_cell(20, 20));
      step();
      want = q_vga.pop_front();
      checks++; if (o_vga_is_wall !== want) begin errors++; $display("FAIL unbuzy_written got %b want %b", o_vga_is_wall, want); end
   endtask

   task automatic test_same_edge();
      bit want;
      @(negedge clk);
      i_req_valid = 1'b1; i_req_write = 1'b1; i_req_x = 6'd5; i_req_y = 6'd5; i_req_wdata = 1'b1;
      i_vga_x = 6'd5; i_vga_y = 6'd5;
      q_vga.push_back(ref_cell(5, 5));
      step();
      ref_map[5 * MAP_W + 5] = 1'b1;
      want = q_vga.pop_front();
      checks++; if (o_vga_is_wall !== want) begin errors++; $display("FAIL same_edge_old got %b want %b", o_vga_is_wall, want); end
      @(negedge clk);
      i_req_valid = 1'b0;
      q_vga.push_back(ref_cell(5, 5));
      step();
      want = q_vga.pop_front();
      checks++; if (o_vga_is_wall !== want) begin errors++; $display("FAIL same_edge_new got %b want %b", o_vga_is_wall, want); end
   endtask

   task automatic test_reinit();
      bit want;
      @(negedge clk);
      i_init = 1'b1;
      i_vga_x = 6'd0; i_vga_y = 6'd5;
      step();
      checks++; if (o_init_done !== 1'b0) begin errors++; $display("FAIL reinit_done_drop got %b want 0", o_init_done); end
      @(negedge clk);
      i_init = 1'b0;
      repeat (1000) step();
      checks++; if (o_init_done !== 1'b0) begin errors++; $display("FAIL reinit_mid got %b want 0", o_init_done); end
      @(negedge clk);
      i_init = 1'b1;
      step();
      @(negedge clk);
      i_init = 1'b0;
      for (int k = 1; k <= CELLS; k++) begin
         step();
         want = (k == CELLS);
         checks++; if (o_init_done !== want) begin errors++; $display("FAIL reinit_done edge %0d got %b want %b", k, o_init_done, want); end
      end
      load_border_model();
      @(negedge clk);
      i_vga_x = 6'd10; i_vga_y = 6'd10;
      q_vga.push_back(ref_cell(10, 10));
      step();
      want = q_vga.pop_front();
      checks++; if (o_vga_is_wall !== want) begin errors++; $display("FAIL reinit_vga_cleared got %b want %b", o_vga_is_wall, want); end
      @(negedge clk);
      i_vga_x = 6'd0; i_vga_y = 6'd5;
      i_req_valid = 1'b1; i_req_write = 1'b0; i_req_x = 6'd10; i_req_y = 6'd10;
      q_vga.push_back(ref_cell(0, 5));
      q_rd.push_back(ref_cell(10, 10));
      step();
      want = q_vga.pop_front();
      checks++; if (o_vga_is_wall !== want) begin errors++; $display("FAIL reinit_vga_border got %b want %b", o_vga_is_wall, want); end
      want = q_rd.pop_front();
      checks++; if (o_req_rvalid !== 1'b1 || o_req_rdata !== want) begin errors++; $display("FAIL reinit_rd rvalid %b rdata %b want 1/%b", o_req_rvalid, o_req_rdata, want); end
      @(negedge clk);
      i_req_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      i_req_valid = 1'b1; i_req_write = 1'b0; i_req_x = 6'd0; i_req_y = 6'd0;
      step();
      checks++; if (o_req_rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid got %b want 1", o_req_rvalid); end
      rst_n = 1'b0;
      #1;
      checks++; if (o_req_rvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_rvalid got %b want 0", o_req_rvalid); end
      checks++; if (o_init_done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got %b want 0", o_init_done); end
      checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b want 0", o_req_ready); end
      @(negedge clk);
      i_req_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_init();
      test_border_sweep();
      test_write_read();
      test_buzy_stall();
      test_same_edge();
      test_reinit();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/map_server.md
Name: map_server

Overview:
- Owns the game-field wall bitmap, MAP_W x MAP_H cells of 1 bit each (1 = wall).
- Answers the VGA renderer's cell requests (request x/y in, is_wall out) every cycle at fixed latency.
- Gives game logic a valid/ready read/write port. That port is blocked while the VGA is scanning visible lines (buzy).
- Contains an init FSM that clears the field and builds the border walls.

Parameters:
MAP_W, 64, cells per row (640 px / 10 px per grid)
MAP_H, 44, game rows (48 grid rows - 4 status-bar rows)
CW, 6, coordinate width in bits

Ports:
clk  in  1  system clock (VGA pixel clock)
rst_n  in  1  asynchronous, active-low reset
i_init  in  1  start or restart the map initialisation sweep (level-sampled)
o_init_done  out  1  high while the map is initialised and serviceable
i_vga_buzy  in  1  VGA is in the vertical display window; game port must stall
i_vga_x  in  CW  VGA requested cell column
i_vga_y  in  CW  VGA requested cell row (game-field relative)
o_vga_is_wall  out  1  wall bit for the VGA request, registered
i_req_valid  in  1  game access request
i_req_write  in  1  1 = write, 0 = read
i_req_x  in  CW  game access column
i_req_y  in  CW  game access row
i_req_wdata  in  1  write data (1 = wall)
o_req_ready  out  1  game access accepted this cycle when valid&ready
o_req_rvalid  out  1  one-cycle pulse: o_req_rdata valid
o_req_rdata  out  1  read result

Behaviour:
- Storage: MAP_W*MAP_H bits, address = y*MAP_W + x (12 bit). Storage is not reset.
- FSM states: IDLE, INIT, READY. Reset -> IDLE.
- Reset values: o_init_done=0, o_vga_is_wall=0, o_req_ready=0, o_req_rvalid=0, o_req_rdata=0. The sweep pointer resets to 0.
- IDLE: i_init=1 sampled -> INIT with pointer=0.
- INIT: each clock writes one cell at the pointer, then increments the pointer, row-major, x fastest.
  - Cell value = 1 if x==0, x==MAP_W-1, y==0 or y==MAP_H-1; otherwise 0.
  - The edge that writes the last cell (63,43) moves the FSM to READY.
  - i_init=1 while in INIT restarts the sweep at pointer 0.
- READY: o_init_done=1. i_init=1 -> INIT with pointer 0, and o_init_done drops after that edge.
- VGA port:
  - o_vga_is_wall is registered. After edge N it equals the cell (i_vga_x, i_vga_y) sampled at edge N.
  - Latency is 1 cycle. The port is served every cycle and is never stalled.
  - o_vga_is_wall is forced to 0 when the state is not READY.
  - i_vga_y >= MAP_H returns 1.
- Game port:
  - o_req_ready = (state==READY) && !i_vga_buzy. It is combinational from the state register and i_vga_buzy.
  - A transaction happens on an edge where i_req_valid && o_req_ready.
  - Read: o_req_rdata and o_req_rvalid=1 are presented for exactly the cycle after acceptance. rvalid is 0 otherwise.
  - Read with i_req_y >= MAP_H returns 1.
  - Write: the cell is updated at the accepting edge. A VGA or game read sampled on the next edge sees the new value.
  - Write with i_req_y >= MAP_H is silently dropped.
- Simultaneous VGA read and game write to the same cell on the same edge: the VGA read returns the old value (read-before-write).
- i_vga_buzy rising while i_req_valid is held: no acceptance until buzy falls. The requester holds x/y/wdata stable, and the request is then accepted on the first non-buzy READY edge.
- Back-to-back accepted reads give back-to-back rvalid pulses.
- Reset mid-INIT or mid-transaction: the FSM returns to IDLE immediately and rvalid clears. Map contents are undefined until the next completed INIT.

Test Plan:
- Reset, i_init pulsed at edge 0 -> INIT at edges 1..2816, o_init_done=1 after edge 2816 and not before; VGA reads in INIT return 0.
- After init, VGA sweep of all 64x44 cells -> is_wall=1 exactly on the border (e.g. (0,5)=1, (63,43)=1, (10,10)=0, (62,42)=0); y=44 returns 1.
- i_vga_buzy=0, write (10,10)=1 -> o_req_ready=1, accepted; VGA request (10,10) on the next edge returns 1; game read (10,10) gives rvalid one cycle later with rdata=1.
- i_vga_buzy=1 with i_req_valid held for 20 cycles -> o_req_ready=0 and no write takes effect; buzy falls -> accepted on that edge.
- VGA read and game write of (5,5)=1 on the same edge (cell was 0) -> VGA returns 0 that time and 1 on the following request.
- i_init asserted in READY and again mid-INIT at pointer 1000 -> o_init_done drops, sweep restarts at 0, done 2816 edges after the last i_init; a previous write at (10,10) is cleared to 0.
